// File: rtl/glacier_pkg.sv
// Shared types and constants for the glacier obstacle scheduler.
package glacier_pkg;

  typedef struct packed {
    logic        active;
    logic [15:0] x;
    logic [15:0] y;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } sched_state_t;

  localparam int unsigned DEFAULT_SPAWN_X = 440;
  localparam int unsigned DEFAULT_SPAWN_Y = 160;
  localparam int unsigned DEFAULT_Y_LIMIT = 600;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;

  // Priority pick: lowest set bit wins, zero when nothing is set.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    lowest_index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_index = 3'(i);
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), steps when en is high, seeds on reset.
module lfsr16
  import glacier_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/glacier_scheduler.sv
// Glacier slot pool: frame-synchronous spawn/move/retire plus per-pixel hit arbitration.
// Optional randomised spawn x is enabled with `define GLACIER_SCHED_LFSR_EN.
module glacier_scheduler
  import glacier_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter int unsigned SPAWN_X      = DEFAULT_SPAWN_X,
  parameter int unsigned SPAWN_Y      = DEFAULT_SPAWN_Y,
  parameter int unsigned Y_LIMIT      = DEFAULT_Y_LIMIT,
  parameter int unsigned DX           = 1,
  parameter int unsigned DY           = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_v_sync,
  input  logic [NUM_SLOTS-1:0]      i_hit_vec,
  output logic [16*NUM_SLOTS-1:0]   o_slot_x,
  output logic [16*NUM_SLOTS-1:0]   o_slot_y,
  output logic [NUM_SLOTS-1:0]      o_slot_active,
  output logic [2:0]                o_sel,
  output logic                      o_hit,
  output logic                      o_busy,
  output logic                      o_overrun
);

  sched_state_t         state;
  sched_state_t         state_next;
  slot_t                slots [NUM_SLOTS];
  logic [2:0]           slot_idx;
  logic [15:0]          spawn_timer;
  logic [15:0]          spawn_x;
  logic [2:0]           spawn_idx;
  logic [NUM_SLOTS-1:0] active_vec;
  logic [NUM_SLOTS-1:0] hit_mask;
  logic                 last_slot;
  logic                 overrun;
  logic                 sync_meta;
  logic                 sync_stable;
  logic                 sync_prev;
  logic                 frame_tick;

  // v_sync comes from another domain: two flops, then a registered rising-edge detect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_meta   <= 1'b0;
      sync_stable <= 1'b0;
      sync_prev   <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      sync_meta   <= i_v_sync;
      sync_stable <= sync_meta;
      sync_prev   <= sync_stable;
      frame_tick  <= sync_stable & ~sync_prev;
    end
  end

`ifdef GLACIER_SCHED_LFSR_EN
  logic [15:0] lfsr_value;

  lfsr16 u_lfsr (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (state == ST_SPAWN),
    .value (lfsr_value)
  );

  assign spawn_x = 16'(SPAWN_X) + {7'd0, lfsr_value[8:0]};
`else
  assign spawn_x = 16'(SPAWN_X);
`endif

  assign last_slot = (slot_idx == 3'(NUM_SLOTS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (frame_tick) state_next = ST_UPDATE;
      ST_UPDATE: if (last_slot) state_next = ST_SPAWN;
      ST_SPAWN:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != ST_IDLE);
  end

  always_comb begin
    active_vec = '0;
    o_slot_x   = '0;
    o_slot_y   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      active_vec[k]        = slots[k].active;
      o_slot_x[16*k +: 16] = slots[k].x;
      o_slot_y[16*k +: 16] = slots[k].y;
    end
  end

  assign o_slot_active = active_vec;
  assign spawn_idx     = lowest_index(8'(~active_vec));
  assign hit_mask      = i_hit_vec & active_vec;
  assign o_hit         = |hit_mask;
  assign o_sel         = lowest_index(8'(hit_mask));
  assign o_overrun     = overrun;

  // Slot state only moves while busy; the x < DX guard keeps x from wrapping below zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= '0;
      spawn_timer <= 16'(SPAWN_PERIOD - 1);
      slot_idx    <= 3'd0;
      overrun     <= 1'b0;
    end else begin
      overrun <= frame_tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (frame_tick) slot_idx <= 3'd0;
        end
        ST_UPDATE: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (3'(k) == slot_idx && slots[k].active) begin
              if (slots[k].y > 16'(Y_LIMIT) || slots[k].x < 16'(DX)) begin
                slots[k].active <= 1'b0;
              end else begin
                slots[k].y <= slots[k].y + 16'(DY);
                slots[k].x <= slots[k].x - 16'(DX);
              end
            end
          end
          if (!last_slot) slot_idx <= slot_idx + 3'd1;
        end
        ST_SPAWN: begin
          if (spawn_timer != 16'd0) begin
            spawn_timer <= spawn_timer - 16'd1;
          end else if (!(&active_vec)) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
              if (3'(k) == spawn_idx) begin
                slots[k].active <= 1'b1;
                slots[k].x      <= spawn_x;
                slots[k].y      <= 16'(SPAWN_Y);
              end
            end
            spawn_timer <= 16'(SPAWN_PERIOD - 1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
